// File: rtl/pkt_dispatcher.sv
// Packet-atomic 1-to-N dispatcher: round-robin pick at sop, locked to the engine until eop.
// Ports: clk/reset, i_data_in/i_valid_in/i_ready_out ingress, o_data_out/o_valid_out/o_ready_in
// engine side, cfg_enable_mask, o_busy, o_err_pulse, o_pkt_count, o_drop_count.
// Optional: define PKT_DISPATCH_STATS_EN to build the packet/drop counters (else tied to 0).
module pkt_dispatcher #(
  parameter int NOC_WIDTH = 600,
  parameter int NUM_OUT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NOC_WIDTH-1:0]  i_data_in,
  input  logic                  i_valid_in,
  output logic                  i_ready_out,
  output logic [NOC_WIDTH-1:0]  o_data_out,
  output logic [NUM_OUT-1:0]    o_valid_out,
  input  logic [NUM_OUT-1:0]    o_ready_in,
  input  logic [NUM_OUT-1:0]    cfg_enable_mask,
  output logic                  o_busy,
  output logic                  o_err_pulse,
  output logic [NUM_OUT*32-1:0] o_pkt_count,
  output logic [15:0]           o_drop_count
);

  localparam int LW = NOC_WIDTH / 4;
  localparam int PW = $clog2(NUM_OUT);
  localparam logic [PW:0] NW = (PW+1)'(NUM_OUT);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0] r_sel;
  logic [PW-1:0] w_sel_nxt;
  logic [PW-1:0] r_rr;
  logic [PW-1:0] w_rr_nxt;
  logic [PW-1:0] w_tgt;
  logic [PW-1:0] w_tgt_inc;
  logic [PW:0]   w_idx;

  logic r_err;
  logic w_err_nxt;
  logic w_sop;
  logic w_eop;
  logic w_found;
  logic w_ready;
  logic w_drop;

  logic [NUM_OUT-1:0] w_elig;
  logic [NUM_OUT-1:0] w_valid;

  assign o_data_out = i_data_in;

  always_comb begin
    w_sop = 1'b0;
    w_eop = 1'b0;
    for (int l = 0; l < 4; l++) begin
      w_sop = w_sop | (i_data_in[(l+1)*LW-1] & i_data_in[(l+1)*LW-2]);
      w_eop = w_eop | (i_data_in[(l+1)*LW-1] & i_data_in[(l+1)*LW-3]);
    end
  end

  // Rotating-priority search starting at r_rr, wrapping modulo NUM_OUT.
  always_comb begin
    w_elig  = cfg_enable_mask & o_ready_in;
    w_found = 1'b0;
    w_tgt   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      w_idx = {1'b0, r_rr} + (PW+1)'(i);
      if (w_idx >= NW) w_idx = w_idx - NW;
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_tgt   = w_idx[PW-1:0];
      end
    end
    w_idx = {1'b0, w_tgt} + (PW+1)'(1);
    if (w_idx >= NW) w_idx = '0;
    w_tgt_inc = w_idx[PW-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rr_nxt    = r_rr;
    w_err_nxt   = 1'b0;
    w_ready     = 1'b0;
    w_valid     = '0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_sop) begin
          if (w_found) begin
            w_ready        = 1'b1;
            w_valid[w_tgt] = i_valid_in;
            if (i_valid_in) begin
              w_sel_nxt = w_tgt;
              w_rr_nxt  = w_tgt_inc;
              if (!w_eop) w_state_nxt = S_BUSY;
            end
          end
        end else begin
          w_ready = 1'b1;
          if (i_valid_in) begin
            w_drop    = 1'b1;
            w_err_nxt = 1'b1;
          end
        end
      end
      S_BUSY: begin
        w_ready        = o_ready_in[r_sel];
        w_valid[r_sel] = i_valid_in;
        if (i_valid_in && w_ready) begin
          if (w_eop) w_state_nxt = S_IDLE;
          // sop inside a packet: forwarded anyway, flagged as missing eop
          if (w_sop) w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_rr    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rr    <= w_rr_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Handshake is forced idle while reset is held so nothing leaks out.
  assign i_ready_out = w_ready & ~reset;
  assign o_valid_out = reset ? '0 : w_valid;
  assign o_busy      = (r_state == S_BUSY);
  assign o_err_pulse = r_err;

`ifdef PKT_DISPATCH_STATS_EN
  logic [31:0]   r_pkt_cnt [NUM_OUT];
  logic [15:0]   r_drop_cnt;
  logic          w_xfer;
  logic          w_done;
  logic [PW-1:0] w_done_idx;

  assign w_xfer = i_valid_in & i_ready_out;
  assign w_done = w_xfer & w_eop &
                  ((r_state == S_BUSY) | w_sop);
  assign w_done_idx = (r_state == S_BUSY) ? r_sel : w_tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) r_pkt_cnt[k] <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_done)
        r_pkt_cnt[w_done_idx] <= r_pkt_cnt[w_done_idx] + 32'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
    assign o_pkt_count[32*k +: 32] = r_pkt_cnt[k];
  end
  assign o_drop_count = r_drop_cnt;
`else
  assign o_pkt_count  = '0;
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_pkt_dispatcher.sv
// Scoreboard bench for pkt_dispatcher: expected engine/flit pushed at drive time,
// popped when the DUT forwards; counters, stalls, error pulses and reset checked directly.
module tb_pkt_dispatcher;

  localparam int NW = 600;
  localparam int NO = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NW-1:0]   i_data_in = '0;
  logic            i_valid_in = 1'b0;
  logic            i_ready_out;
  logic [NW-1:0]   o_data_out;
  logic [NO-1:0]   o_valid_out;
  logic [NO-1:0]   o_ready_in = '1;
  logic [NO-1:0]   cfg_enable_mask = '1;
  logic            o_busy;
  logic            o_err_pulse;
  logic [NO*32-1:0] o_pkt_count;
  logic [15:0]     o_drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int q_eng[$];
  logic [NW-1:0] q_dat[$];
  int exp_pkt[NO];
  int exp_drop;
  logic [15:0] tag = 16'h1000;
  int w;

  pkt_dispatcher #(.NOC_WIDTH(NW), .NUM_OUT(NO)) dut (
    .clk(clk), .reset(reset),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in),
    .i_ready_out(i_ready_out), .o_data_out(o_data_out),
    .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
    .cfg_enable_mask(cfg_enable_mask), .o_busy(o_busy),
    .o_err_pulse(o_err_pulse), .o_pkt_count(o_pkt_count),
    .o_drop_count(o_drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [NW-1:0] act,
                     input logic [NW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", t, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk(input int lane, input bit sop,
                                       input bit eop, input logic [15:0] tg);
    logic [NW-1:0] d;
    d = '0;
    d[lane*150+149] = 1'b1;
    d[lane*150+148] = sop;
    d[lane*150+147] = eop;
    d[15:0] = tg;
    d[300 +: 16] = ~tg;
    return d;
  endfunction

  // Sends one flit; eng < 0 means the flit must not reach any engine.
  task automatic xfer(input logic [NW-1:0] d, input int eng, output int waits);
    bit t;
    waits = 0;
    if (eng >= 0) begin
      q_eng.push_back(eng);
      q_dat.push_back(d);
    end
    i_data_in = d;
    i_valid_in = 1'b1;
    while (1) begin
      @(negedge clk);
      t = i_ready_out;
      @(posedge clk);
      #1;
      if (t) break;
      waits++;
      if (waits > 20) begin
        chk("timeout", 0, 1);
        break;
      end
    end
    i_valid_in = 1'b0;
    tag = tag + 16'd1;
  endtask

  task automatic pkt1(input int lane, input int eng);
    int wt;
    xfer(mk(lane, 1, 1, tag), eng, wt);
    exp_pkt[eng]++;
  endtask

  task automatic chk_counts(input string t);
    logic [31:0] want;
    for (int k = 0; k < NO; k++) begin
`ifdef PKT_DISPATCH_STATS_EN
      want = exp_pkt[k];
`else
      want = 0;
`endif
      chk(t, o_pkt_count[32*k +: 32], want);
    end
`ifdef PKT_DISPATCH_STATS_EN
    want = exp_drop;
`else
    want = 0;
`endif
    chk(t, o_drop_count, want);
  endtask

  task automatic clr_exp();
    for (int k = 0; k < NO; k++) exp_pkt[k] = 0;
    exp_drop = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_exp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid_out, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err_pulse, 0);
    reset = 1'b0;
    #1;
    chk_counts("rst_cnt");
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("onehot", $onehot0(o_valid_out), 1);
      if (|(o_valid_out & o_ready_in)) begin
        if (q_eng.size() == 0) begin
          chk("unexp_fwd", o_valid_out, 0);
        end else begin
          chk("fwd_eng", o_valid_out, 4'b0001 << q_eng.pop_front());
          chk("fwd_data", o_data_out, q_dat.pop_front());
        end
      end
    end
  end

  initial begin
    clr_exp();
    do_reset();
    chk("idle_ready", i_ready_out, 1);

    // round robin, no bubbles, sop/eop in varied lanes
    for (int p = 0; p < 5; p++) begin
      xfer(mk(p % 4, 1, 1, tag), p % 4, w);
      exp_pkt[p % 4]++;
      chk("t1_bubble", w, 0);
    end
    chk_counts("t1_cnt");

    // back-pressure mid-packet
    do_reset();
    xfer(mk(0, 1, 0, tag), 0, w);
    i_data_in = mk(0, 0, 0, tag);
    i_valid_in = 1'b1;
    o_ready_in = 4'b1110;
    @(negedge clk);
    chk("t2_stall_rdy", i_ready_out, 0);
    chk("t2_stall_vld", o_valid_out, 4'b0001);
    chk("t2_busy", o_busy, 1);
    @(posedge clk);
    #1;
    o_ready_in = 4'b1111;
    xfer(mk(0, 0, 0, tag), 0, w);
    xfer(mk(0, 0, 1, tag), 0, w);
    exp_pkt[0]++;
    chk("t2_idle", o_busy, 0);
    pkt1(0, 1);
    chk_counts("t2_cnt");

    // enable mask, and mask change during a packet
    do_reset();
    cfg_enable_mask = 4'b1010;
    pkt1(0, 1);
    pkt1(1, 3);
    pkt1(2, 1);
    xfer(mk(0, 1, 0, tag), 3, w);
    cfg_enable_mask = 4'b0001;
    xfer(mk(3, 0, 1, tag), 3, w);
    exp_pkt[3]++;
    pkt1(0, 0);
    chk_counts("t3_cnt");

    // non-sop flits in IDLE are dropped
    i_data_in = mk(0, 0, 0, tag);
    i_valid_in = 1'b1;
    @(negedge clk);
    chk("t4_vld", o_valid_out, 0);
    chk("t4_rdy", i_ready_out, 1);
    @(posedge clk);
    #1;
    i_valid_in = 1'b0;
    exp_drop++;
    chk("t4_err_hi", o_err_pulse, 1);
    chk_counts("t4_cnt1");
    @(posedge clk);
    #1;
    chk("t4_err_lo", o_err_pulse, 0);
    i_data_in = mk(0, 0, 0, tag);
    i_data_in[298] = 1'b1;
    xfer(i_data_in, -1, w);
    exp_drop++;
    chk("t4_err2", o_err_pulse, 1);
    chk_counts("t4_cnt2");

    // rotation skips unready engines; stall with nobody ready
    cfg_enable_mask = 4'b1111;
    o_ready_in = 4'b1101;
    pkt1(0, 2);
    o_ready_in = 4'b0000;
    i_data_in = mk(0, 1, 1, tag);
    i_valid_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_stall_rdy", i_ready_out, 0);
      chk("t5_stall_vld", o_valid_out, 0);
    end
    @(posedge clk);
    #1;
    o_ready_in = 4'b0001;
    pkt1(0, 0);
    o_ready_in = 4'b1111;
    chk_counts("t5_cnt");

    // sop inside a packet: forwarded to the locked engine, error pulse
    xfer(mk(0, 1, 0, tag), 1, w);
    xfer(mk(1, 1, 0, tag), 1, w);
    chk("mid_sop_err", o_err_pulse, 1);
    chk("mid_sop_busy", o_busy, 1);
    xfer(mk(0, 0, 1, tag), 1, w);
    exp_pkt[1]++;
    chk("mid_sop_err_lo", o_err_pulse, 0);
    chk_counts("mid_sop_cnt");

    // reset in the middle of a packet
    xfer(mk(0, 1, 0, tag), 2, w);
    xfer(mk(0, 0, 0, tag), 2, w);
    i_data_in = mk(0, 0, 1, tag);
    i_valid_in = 1'b1;
    reset = 1'b1;
    clr_exp();
    #1;
    chk("t6_vld", o_valid_out, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_rdy", i_ready_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    xfer(mk(0, 0, 1, tag), -1, w);
    exp_drop++;
    chk("t6_err", o_err_pulse, 1);
    pkt1(0, 0);
    chk("t6_err_lo", o_err_pulse, 0);
    chk_counts("t6_cnt");

    repeat (2) @(posedge clk);
    chk("q_empty", q_eng.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
